adder_result_display: RTL

Downstream stage of the 4-bit ripple adder (`fourgate`).
- Captures the adder's `{cout, sum}` result on a load strobe and converts the 5-bit value (0–31) to two BCD digits.
- Counts accepted loads in a 2-digit BCD counter.
- Drives a 4-digit, time-multiplexed, active-low 7-segment display on the Spartan-3 board.

---
 rtl/adder_result_display.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/adder_result_display.sv
// Captures the 4-bit adder result on a load edge, converts it to BCD, counts loads,
// and scans both onto a 4-digit active-low multiplexed 7-segment display.
module adder_result_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sum,
   input  logic       cout,
   input  logic       load,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int                PRE_W   = $clog2(REFRESH_DIV);
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(REFRESH_DIV - 1);
   localparam logic [6:0]        SEG_OFF = 7'b1111111;

   typedef enum logic [1:0] {
      DIG_UNITS  = 2'd0,
      DIG_TENS   = 2'd1,
      DIG_CNT_LO = 2'd2,
      DIG_CNT_HI = 2'd3
   } digit_e;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   logic             load_q;
   logic [4:0]       value_q,  value_d;
   logic             ovf_q,    ovf_d;
   logic [1:0]       tens_q,   tens_d;
   logic [3:0]       units_q,  units_d;
   logic [3:0]       cnt_lo_q, cnt_lo_d;
   logic [3:0]       cnt_hi_q, cnt_hi_d;
   logic [PRE_W-1:0] pre_q,    pre_d;
   digit_e           digit_q,  digit_d;
   logic [3:0]       an_q,     an_d;
   logic [6:0]       seg_q,    seg_d;
   logic             dp_q,     dp_d;
   logic             load_p;
   logic             wrap;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      load_p   = load & ~load_q;
      value_d  = value_q;
      ovf_d    = ovf_q;
      cnt_lo_d = cnt_lo_q;
      cnt_hi_d = cnt_hi_q;
      if (load_p) begin
         value_d = {cout, sum};
         ovf_d   = cout;
         if (cnt_lo_q == 4'd9) begin
            cnt_lo_d = 4'd0;
            cnt_hi_d = (cnt_hi_q == 4'd9) ? 4'd0 : cnt_hi_q + 4'd1;
         end else begin
            cnt_lo_d = cnt_lo_q + 4'd1;
         end
      end
   end

   // Value never exceeds 31, so three compares replace a general divider.
   always_comb begin
      tens_d  = 2'd0;
      units_d = value_q[3:0];
      if (value_q >= 5'd30) begin
         tens_d  = 2'd3;
         units_d = 4'(value_q - 5'd30);
      end else if (value_q >= 5'd20) begin
         tens_d  = 2'd2;
         units_d = 4'(value_q - 5'd20);
      end else if (value_q >= 5'd10) begin
         tens_d  = 2'd1;
         units_d = 4'(value_q - 5'd10);
      end
   end

   always_comb begin
      wrap    = (pre_q == PRE_MAX);
      pre_d   = wrap ? '0 : pre_q + PRE_W'(1);
      digit_d = wrap ? digit_e'(digit_q + 2'd1) : digit_q;
   end

   always_comb begin
      an_d  = ~(4'b0001 << 2'(digit_q));
      seg_d = SEG_OFF;
      unique case (digit_q)
         DIG_UNITS:  seg_d = seg_of(units_q);
         DIG_TENS:   seg_d = (tens_q == 2'd0) ? SEG_OFF : seg_of({2'b00, tens_q});
         DIG_CNT_LO: seg_d = seg_of(cnt_lo_q);
         DIG_CNT_HI: seg_d = seg_of(cnt_hi_q);
         default:    seg_d = SEG_OFF;
      endcase
      dp_d = ~((digit_q == DIG_UNITS) & ovf_q);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q   <= 1'b0;
         value_q  <= '0;
         ovf_q    <= 1'b0;
         tens_q   <= '0;
         units_q  <= '0;
         cnt_lo_q <= '0;
         cnt_hi_q <= '0;
         pre_q    <= '0;
         digit_q  <= DIG_UNITS;
         an_q     <= 4'b1110;
         seg_q    <= 7'b1000000;
         dp_q     <= 1'b1;
      end else begin
         load_q   <= load;
         value_q  <= value_d;
         ovf_q    <= ovf_d;
         tens_q   <= tens_d;
         units_q  <= units_d;
         cnt_lo_q <= cnt_lo_d;
         cnt_hi_q <= cnt_hi_d;
         pre_q    <= pre_d;
         digit_q  <= digit_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
